// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide op codes, FSM states
// and the two's-complement conditional negate used on operands and results.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    localparam int MD_ITER = 32;

    function automatic logic [31:0] negate32(
        input logic [31:0] x,
        input logic        en
    );
        return en ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Works on magnitudes for 32 cycles, then sign-corrects and commits in FIX.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e   state, nstate;
    logic [4:0]  cnt;
    logic [1:0]  opq;
    logic [63:0] acc;
    logic [31:0] mcand;
    logic        sgn_lo;
    logic        sgn_hi;
    logic        dz;

    logic        sgnd;
    logic [31:0] am, bm;
    logic [32:0] add33;
    logic [63:0] mul_nxt;
    logic [33:0] diff;
    logic [63:0] div_nxt;
    logic [63:0] prod;

    assign sgnd = ~op[0];
    assign am   = negate32(a, sgnd & a[31]);
    assign bm   = negate32(b, sgnd & b[31]);

    // acc[63:32] is the partial product / remainder, acc[31:0] the
    // shifting multiplier / dividend-into-quotient register.
    assign add33   = {1'b0, acc[63:32]} + {1'b0, mcand};
    assign mul_nxt = acc[0] ? {add33, acc[31:1]} : {1'b0, acc[63:1]};

    assign diff    = {1'b0, acc[63:31]} - {2'b00, mcand};
    assign div_nxt = diff[33] ? {acc[62:0], 1'b0}
                              : {diff[31:0], acc[30:0], 1'b1};

    assign prod = sgn_lo ? (~acc + 64'd1) : acc;

    always_comb begin
        nstate = state;
        unique case (state)
            MD_IDLE: if (start) nstate = MD_RUN;
            MD_RUN:  if (cnt == 5'(MD_ITER - 1)) nstate = MD_FIX;
            MD_FIX:  nstate = MD_IDLE;
            default: nstate = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            opq    <= '0;
            acc    <= '0;
            mcand  <= '0;
            sgn_lo <= 1'b0;
            sgn_hi <= 1'b0;
            dz     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= nstate;
            busy  <= (nstate != MD_IDLE);
            done  <= (state == MD_FIX);
            unique case (state)
                MD_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        opq    <= op;
                        cnt    <= '0;
                        sgn_lo <= sgnd & (a[31] ^ b[31]);
                        sgn_hi <= sgnd & a[31];
                        dz     <= (b == '0);
                        if (op[1]) begin
                            acc   <= {32'd0, am};
                            mcand <= bm;
                        end else begin
                            acc   <= {32'd0, bm};
                            mcand <= am;
                        end
                    end
                end
                MD_RUN: begin
                    acc <= opq[1] ? div_nxt : mul_nxt;
                    cnt <= cnt + 5'd1;
                end
                MD_FIX: begin
                    // Divide by zero leaves |a| in the remainder, so the
                    // sign-corrected HI is the raw dividend.
                    if (opq[1]) begin
                        lo <= dz ? '1 : negate32(acc[31:0], sgn_lo);
                        hi <= negate32(acc[63:32], sgn_hi);
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
